// File: rtl/seq_det_pkg.sv
// Shared constants and helpers for the serial pattern detector.
// Holds the length limit, the default pattern and the valid-count width helper.
package seq_det_pkg;

    localparam int SEQ_DET_LEN_MAX = 16;
    localparam int SEQ_DET_LEN_DEF = 3;
    localparam logic [SEQ_DET_LEN_MAX-1:0] SEQ_DET_PATTERN_DEF = 16'b111;

    // Width needed to hold a valid-bit count in the range 0..len.
    function automatic int cnt_width(input int len);
        return $clog2(len + 1);
    endfunction

endpackage

// File: rtl/seq_det_if.sv
// Serial bit-in / detect-flag-out bundle for seq_det.
// The master drives B and observes w; the detector is the slave.
interface seq_det_if;

    logic B;
    logic w;

    modport master (output B, input w);
    modport slave  (input B, output w);

endinterface

// File: rtl/seq_det_hist.sv
// Sample history shift register plus a saturating valid-bit counter with clear.
// Exposes the next history (nh) and the next count (nc) to the compare logic.
module seq_det_hist
    import seq_det_pkg::*;
#(
    parameter int LEN = SEQ_DET_LEN_DEF,
    parameter int CW  = cnt_width(SEQ_DET_LEN_DEF)
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           b,
    input  logic           clr,
    output logic [LEN-1:0] nh,
    output logic [CW-1:0]  nc
);

    // The oldest history bit is shifted out before it is ever compared,
    // so only the newest LEN-1 samples need to be stored.
    logic [LEN-2:0] hist_q, hist_d;
    logic [CW-1:0]  cnt_q, cnt_d;

    always_comb begin
        nh     = {hist_q, b};
        nc     = (cnt_q == CW'(LEN)) ? cnt_q : cnt_q + CW'(1);
        hist_d = nh[LEN-2:0];
        cnt_d  = clr ? '0 : nc;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hist_q <= '0;
            cnt_q  <= '0;
        end else begin
            hist_q <= hist_d;
            cnt_q  <= cnt_d;
        end
    end

endmodule

// File: rtl/seq_det.sv
// Serial bit-pattern detector: raises w for one cycle when the last LEN
// sampled bits equal PATTERN (MSB oldest), counting only post-reset samples.
module seq_det
    import seq_det_pkg::*;
#(
    parameter int                         LEN     = SEQ_DET_LEN_DEF,
    parameter logic [SEQ_DET_LEN_MAX-1:0] PATTERN = SEQ_DET_PATTERN_DEF,
    parameter bit                         OVERLAP = 1'b1
) (
    input  logic       Clk,
    input  logic       Rst,
    seq_det_if.slave   bus
);

    localparam int CW = cnt_width(LEN);

    generate
        if (LEN < 2 || LEN > SEQ_DET_LEN_MAX) begin : g_bad_len
            $error("seq_det: LEN must be in 2..%0d", SEQ_DET_LEN_MAX);
        end
        if (LEN < SEQ_DET_LEN_MAX) begin : g_pat_chk
            if ((PATTERN >> LEN) != '0) begin : g_bad_pattern
                $error("seq_det: PATTERN does not fit in LEN bits");
            end
        end
    endgenerate

    logic [LEN-1:0] nh;
    logic [CW-1:0]  nc;
    logic           match;
    logic           cnt_clr;
    logic           w_d, w_q;

    seq_det_hist #(
        .LEN (LEN),
        .CW  (CW)
    ) u_hist (
        .clk   (Clk),
        .rst_n (Rst),
        .b     (bus.B),
        .clr   (cnt_clr),
        .nh    (nh),
        .nc    (nc)
    );

    // A full count is required so reset-loaded zeros never form a match;
    // without overlap the count restarts so the next hit needs LEN fresh bits.
    always_comb begin
        match   = (nc == CW'(LEN)) && (nh == PATTERN[LEN-1:0]);
        cnt_clr = match && !OVERLAP;
        w_d     = match;
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            w_q <= 1'b0;
        end else begin
            w_q <= w_d;
        end
    end

    assign bus.w = w_q;

endmodule

// File: tb/tb_seq_det.sv
// Directed bench for seq_det: five instances (111/ov1, 111/ov0, 101/ov1,
// 101/ov0, 000/ov1) share B and reset; expected w vectors are hand-computed.
module tb_seq_det;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic b_drv = 1'b1;
    int   chk_cnt  = 0;
    int   pass_cnt = 0;

    always #5 clk = ~clk;

    seq_det_if if_a ();
    seq_det_if if_b ();
    seq_det_if if_c ();
    seq_det_if if_d ();
    seq_det_if if_e ();

    assign if_a.B = b_drv;
    assign if_b.B = b_drv;
    assign if_c.B = b_drv;
    assign if_d.B = b_drv;
    assign if_e.B = b_drv;

    seq_det #(.LEN(3), .PATTERN(16'b111), .OVERLAP(1'b1)) u_a (.Clk(clk), .Rst(rst_n), .bus(if_a.slave));
    seq_det #(.LEN(3), .PATTERN(16'b111), .OVERLAP(1'b0)) u_b (.Clk(clk), .Rst(rst_n), .bus(if_b.slave));
    seq_det #(.LEN(3), .PATTERN(16'b101), .OVERLAP(1'b1)) u_c (.Clk(clk), .Rst(rst_n), .bus(if_c.slave));
    seq_det #(.LEN(3), .PATTERN(16'b101), .OVERLAP(1'b0)) u_d (.Clk(clk), .Rst(rst_n), .bus(if_d.slave));
    seq_det #(.LEN(3), .PATTERN(16'b000), .OVERLAP(1'b1)) u_e (.Clk(clk), .Rst(rst_n), .bus(if_e.slave));

    // Bit order: {111/ov1, 111/ov0, 101/ov1, 101/ov0, 000/ov1}
    logic [4:0] w_all;
    assign w_all = {if_a.w, if_b.w, if_c.w, if_d.w, if_e.w};

    task automatic check(input string tag, input logic [4:0] got, input logic [4:0] exp);
        chk_cnt++;
        if (got === exp) begin
            pass_cnt++;
            $display("[%0t] %s w=%b ok", $time, tag, got);
        end else begin
            $display("[%0t] FAIL %s: w=%b expected %b", $time, tag, got, exp);
        end
    endtask

    // Drive one bit, let one rising edge sample it, check 1 time unit later.
    task automatic step(input string tag, input logic bv, input logic [4:0] exp);
        b_drv = bv;
        @(posedge clk);
        #1;
        check(tag, w_all, exp);
    endtask

    task automatic do_reset(input string tag);
        rst_n = 1'b0;
        #1;
        check({tag, "_async"}, w_all, 5'b00000);
        @(posedge clk);
        #1;
        check({tag, "_hold"}, w_all, 5'b00000);
        rst_n = 1'b1;
    endtask

    initial begin
        // Reset held with B=1: nothing may detect.
        step("rst_b1_e1", 1'b1, 5'b00000);
        step("rst_b1_e2", 1'b1, 5'b00000);
        step("rst_b1_e3", 1'b1, 5'b00000);
        rst_n = 1'b1;

        // Overlap test stream 1,1,1,1,1,0,1.
        step("ovl_1", 1'b1, 5'b00000);
        step("ovl_2", 1'b1, 5'b00000);
        step("ovl_3", 1'b1, 5'b11000);
        step("ovl_4", 1'b1, 5'b10000);
        step("ovl_5", 1'b1, 5'b10000);
        step("ovl_6", 1'b0, 5'b00000);
        step("ovl_7", 1'b1, 5'b00110);

        // Reset while w is high must drop it without a clock edge.
        #2;
        do_reset("rst_w_hi");

        // Partial 1,1 then reset, then 1,0,1: default pattern must not fire.
        step("part_1", 1'b1, 5'b00000);
        step("part_2", 1'b1, 5'b00000);
        do_reset("rst_part");
        step("post_1", 1'b1, 5'b00000);
        step("post_2", 1'b0, 5'b00000);
        step("post_3", 1'b1, 5'b00110);

        // Pattern 101 stream 1,0,1,0,1.
        do_reset("rst_101");
        step("p101_1", 1'b1, 5'b00000);
        step("p101_2", 1'b0, 5'b00000);
        step("p101_3", 1'b1, 5'b00110);
        step("p101_4", 1'b0, 5'b00000);
        step("p101_5", 1'b1, 5'b00100);

        // Pattern 000 needs three real zeros after reset.
        do_reset("rst_000");
        step("p000_1", 1'b0, 5'b00000);
        step("p000_2", 1'b0, 5'b00000);
        step("p000_3", 1'b0, 5'b00001);
        step("p000_4", 1'b0, 5'b00001);
        step("p000_5", 1'b1, 5'b00000);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/seq_det.md
# seq_det

Serial bit-pattern detector. It samples one input bit `B` per rising `Clk` edge and raises the registered flag `w` for one cycle whenever the last `LEN` sampled bits equal `PATTERN`. It sits on a serial data path as a framing/marker recognizer. Detection never uses bits sampled before the most recent reset.

## Interface
- `LEN`, default 3: pattern length in bits; legal range 2..16.
- `PATTERN`, default 3'b111: target sequence; MSB is the oldest bit, LSB is the newest.
- `OVERLAP`, default 1: 1 lets matches share bits; 0 restarts the search after each match.
- `Clk` input 1: single system clock; all state is updated on its rising edge.
- `Rst` input 1: reset, asynchronous and active-low.
- `B` input 1: serial data bit, sampled on each rising `Clk` edge.
- `w` output 1: registered detect flag; 1 for exactly one cycle per match.

## Operation
- State:
  - `hist[LEN-1:0]`: shift register of the sampled bits.
  - `cnt`: number of valid bits held in `hist`, range 0..LEN.
- Reset (`Rst`=0): immediately forces `hist`=0, `cnt`=0, `w`=0, independent of `Clk`. These values hold while `Rst` stays low.
- Each rising `Clk` edge with `Rst`=1:
  - `nh = {hist[LEN-2:0], B}`.
  - `nc = min(cnt+1, LEN)`.
  - `match = (nc == LEN) && (nh == PATTERN)`.
  - `hist <= nh`; `w <= match`.
  - `cnt <= (match && !OVERLAP) ? 0 : nc`.
- Zeros loaded by reset never count toward a match. Example: `PATTERN`=000 needs three real sampled zeros after reset.
- `OVERLAP`=1 with default pattern: input 1,1,1,1,1 gives `w`=0,0,1,1,1.
- `OVERLAP`=0 with default pattern: input 1,1,1,1,1,1 gives `w`=0,0,1,0,0,1.
- Equivalent view: a Moore FSM with states S0..S(LEN-1) for partial-match progress plus a DETECT state. Any implementation must match the cycle behaviour above exactly.

## Timing
- Latency: `w` goes high after the same rising edge that samples the final pattern bit.
  - `w` is a flop output, so it is valid for the following full clock period.
- `B` must be stable around the rising edge. It may change anywhere else in the cycle, for example mid-low phase.
- Reset mid-sequence: partial progress is discarded. After `Rst` returns high, the full `LEN` bits are required again.
- Reset asserted while `w`=1: `w` drops asynchronously.
- Reset release: the first edge with `Rst`=1 samples `B` as bit 1 of the new history. Release timing must be synchronized externally to `Clk`.
- No enable or handshake: every edge consumes one bit.

## Structure
- Shared package `seq_det_pkg`:
  - `SEQ_DET_LEN_MAX` = 16.
  - Default `PATTERN`/`LEN` constants.
  - Count-width function `$clog2(LEN+1)`.
- One natural sub-module, `seq_det_hist`: the shift register plus saturating valid-counter with clear, exposing `nh` and `nc`.
- The top level holds the compare, the `OVERLAP` clear logic and the `w` flop.
- Elaboration-time check: `LEN` in 2..16, and `PATTERN` fits in `LEN` bits.

## Test plan
- Reset: hold `Rst`=0 with `B`=1 for several edges → `w`=0 and `cnt`=0 throughout. Assert `Rst`=0 while `w`=1 → `w`=0 immediately, with no clock edge.
- Default detect: release reset, drive B=1,1,1 → `w`=0,0,1, with `w` high after the third edge.
- Reset interrupts partial match: B=1,1, then `Rst` low, then B=1,0,1 → `w` never asserts.
- Overlap: `OVERLAP`=1, B=1,1,1,1,1,0,1 → `w`=0,0,1,1,1,0,0. With `OVERLAP`=0 and the same input → `w`=0,0,1,0,0,0,0.
- Non-default pattern: `PATTERN`=3'b101, `OVERLAP`=1, B=1,0,1,0,1 → `w`=0,0,1,0,1. With `OVERLAP`=0 → `w`=0,0,1,0,0.
- All-zero pattern after reset: `PATTERN`=3'b000, B=0,0,0 → `w`=0,0,1. The reset-cleared history must not cause an earlier hit.
